// File: rtl/multi_count_fifo_pkg.sv
// Shared types and constants for the multi-channel gated photon counter.
// MULTI_COUNT_FIFO_SEQ_EN adds an 8-bit window sequence tag above the counts.
package multi_count_fifo_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, COMMIT} state_e;

  localparam int SEQ_W  = 8;
  localparam int DROP_W = 16;

  function automatic int word_w(input int channels, input int width);
`ifdef MULTI_COUNT_FIFO_SEQ_EN
    return channels * width + SEQ_W;
`else
    return channels * width;
`endif
  endfunction

endpackage

// File: rtl/multi_count_fifo_if.sv
// PMT/gate inputs and PS-side FIFO read port of multi_count_fifo.
// Word width follows MULTI_COUNT_FIFO_SEQ_EN through word_w().
interface multi_count_fifo_if
  import multi_count_fifo_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 7,
  parameter int SIZE     = 10
) ();
  localparam int WORD_W = word_w(CHANNELS, WIDTH);

  logic                gate;
  logic [CHANNELS-1:0] pmt;
  logic                rd_en;
  logic                clr_err;
  logic [WORD_W-1:0]   data;
  logic                data_valid;
  logic [SIZE:0]       usage;
  logic                empty;
  logic                full;
  logic                intr;
  logic [DROP_W-1:0]   drop_cnt;

  modport master (
    output gate, pmt, rd_en, clr_err,
    input  data, data_valid, usage, empty, full, intr, drop_cnt
  );

  modport slave (
    input  gate, pmt, rd_en, clr_err,
    output data, data_valid, usage, empty, full, intr, drop_cnt
  );
endinterface

// File: rtl/multi_count_fifo_fifo.sv
// Single-clock FIFO with registered read port and occupancy flags.
// Flags derive from the registered usage count, so they reflect the last edge.
module mc_sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic [AW:0]   usage,
  output logic          empty,
  output logic          full
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_wr, do_rd;

  assign empty = (usage == '0);
  assign full  = (usage == DEPTH);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      usage    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      unique case ({do_wr, do_rd})
        2'b10:   usage <= usage + (AW+1)'(1);
        2'b01:   usage <= usage - (AW+1)'(1);
        default: usage <= usage;
      endcase
    end
  end
endmodule

// File: rtl/multi_count_fifo.sv
// Gated multi-channel PMT edge counter committing one packed word per window.
// MULTI_COUNT_FIFO_SEQ_EN prepends an 8-bit window sequence tag to each word.
module multi_count_fifo
  import multi_count_fifo_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 7,
  parameter int SIZE     = 10,
  parameter int THRESH   = 512
) (
  input  logic             clk,
  input  logic             rst,
  multi_count_fifo_if.slave bus
);
  localparam int            WORD_W  = word_w(CHANNELS, WIDTH);
  localparam logic [SIZE:0] THR     = (SIZE+1)'(THRESH);

  logic [CHANNELS-1:0]             pmt_s1, pmt_s2, pmt_prev, pmt_rise;
  logic                            gate_q;
  state_e                          state, state_nx;
  logic [CHANNELS-1:0][WIDTH-1:0]  cnt;
  logic                            push, drop;
  logic [WORD_W-1:0]               word;
  logic [SIZE:0]                   usage;
  logic                            fifo_full;

  // Two-flop synchroniser plus one more stage for the rise detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      pmt_s1   <= '0;
      pmt_s2   <= '0;
      pmt_prev <= '0;
      gate_q   <= 1'b0;
    end else begin
      pmt_s1   <= bus.pmt;
      pmt_s2   <= pmt_s1;
      pmt_prev <= pmt_s2;
      gate_q   <= bus.gate;
    end
  end

  assign pmt_rise = pmt_s2 & ~pmt_prev;

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    drop     = 1'b0;
    unique case (state)
      IDLE:   if (gate_q) state_nx = COUNT;
      COUNT:  if (!gate_q) state_nx = COMMIT;
      COMMIT: begin
        push     = ~fifo_full;
        drop     = fifo_full;
        state_nx = gate_q ? COUNT : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counters saturate rather than wrap so an overrun window still reads as "at least max".
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (rst || state == COMMIT)
        cnt[i] <= '0;
      else if (state == COUNT && pmt_rise[i] && cnt[i] != '1)
        cnt[i] <= cnt[i] + WIDTH'(1);
    end
  end

`ifdef MULTI_COUNT_FIFO_SEQ_EN
  logic [SEQ_W-1:0] seq;

  // Advances on dropped windows too, so gaps in the tag reveal lost windows.
  always_ff @(posedge clk)
    if (rst)                  seq <= '0;
    else if (state == COMMIT) seq <= seq + SEQ_W'(1);

  assign word = {seq, cnt};
`else
  assign word = cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      bus.drop_cnt <= '0;
    else if (bus.clr_err)
      bus.drop_cnt <= DROP_W'(drop);
    else if (drop && bus.drop_cnt != '1)
      bus.drop_cnt <= bus.drop_cnt + DROP_W'(1);
  end

  always_ff @(posedge clk)
    if (rst) bus.intr <= 1'b0;
    else     bus.intr <= (usage >= THR);

  mc_sync_fifo #(
    .W  (WORD_W),
    .AW (SIZE)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push),
    .wr_data  (word),
    .rd_en    (bus.rd_en),
    .rd_data  (bus.data),
    .rd_valid (bus.data_valid),
    .usage    (usage),
    .empty    (bus.empty),
    .full     (fifo_full)
  );

  assign bus.usage = usage;
  assign bus.full  = fifo_full;
endmodule

// File: tb/tb_multi_count_fifo.sv
// Directed bench for multi_count_fifo: queue-based window model checked every cycle,
// plus literal expectations; tag checks appear when MULTI_COUNT_FIFO_SEQ_EN is defined.
module tb_multi_count_fifo;
  import multi_count_fifo_pkg::*;

  localparam int CH    = 4;
  localparam int W     = 7;
  localparam int SZ    = 10;
  localparam int TH    = 4;
  localparam int DEPTH = 1 << SZ;
  localparam int WW    = word_w(CH, W);
  localparam int CMAX  = (1 << W) - 1;

  localparam int P_IDLE = 0, P_COUNT = 1, P_COMMIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multi_count_fifo_if #(.CHANNELS(CH), .WIDTH(W), .SIZE(SZ)) bus ();

  multi_count_fifo #(.CHANNELS(CH), .WIDTH(W), .SIZE(SZ), .THRESH(TH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- model state ----------------
  logic [WW-1:0] m_q [$];
  logic [WW-1:0] m_data;
  bit            m_valid, m_intr, m_ok;
  int            m_phase, m_seq, m_drop, m_gq, m_before;
  int            m_cnt [CH];
  logic [CH-1:0] m_hist [3];   // pmt samples from 1, 2, 3 edges ago
  logic          s_rst, s_gate, s_rd, s_clr, m_dropped;
  logic [CH-1:0] s_pmt, m_rise;

  function automatic logic [WW-1:0] model_word();
    logic [WW-1:0] w = '0;
    for (int i = 0; i < CH; i++) w[i*W +: W] = W'(m_cnt[i]);
`ifdef MULTI_COUNT_FIFO_SEQ_EN
    w[WW-1 -: SEQ_W] = SEQ_W'(m_seq);
`endif
    return w;
  endfunction

  initial begin : model
    m_ok = 1'b0;
    forever begin
      @(posedge clk);
      s_rst = rst; s_gate = bus.gate; s_pmt = bus.pmt; s_rd = bus.rd_en; s_clr = bus.clr_err;
      @(negedge clk);
      if (s_rst) begin
        m_q.delete();
        m_data = '0; m_valid = 0; m_intr = 0; m_ok = 1;
        m_phase = P_IDLE; m_seq = 0; m_drop = 0; m_gq = 0;
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
      end else if (m_ok) begin
        m_before  = m_q.size();
        m_rise    = m_hist[1] & ~m_hist[2];
        m_dropped = 1'b0;
        m_intr    = (m_before >= TH);
        m_valid   = 1'b0;
        if (s_rd && m_before > 0) begin
          m_data  = m_q.pop_front();
          m_valid = 1'b1;
        end
        case (m_phase)
          P_COUNT: begin
            for (int i = 0; i < CH; i++)
              if (m_rise[i] && m_cnt[i] < CMAX) m_cnt[i]++;
            m_phase = m_gq ? P_COUNT : P_COMMIT;
          end
          P_COMMIT: begin
            if (m_before < DEPTH) m_q.push_back(model_word());
            else m_dropped = 1'b1;
            m_seq = (m_seq + 1) % 256;
            for (int i = 0; i < CH; i++) m_cnt[i] = 0;
            m_phase = m_gq ? P_COUNT : P_IDLE;
          end
          default: m_phase = m_gq ? P_COUNT : P_IDLE;
        endcase
        if (s_clr) m_drop = m_dropped ? 1 : 0;
        else if (m_dropped && m_drop < 65535) m_drop++;
        m_gq = s_gate;
        m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = s_pmt;
      end
      if (m_ok) begin
        n_vec++;
        if (bus.data !== m_data || bus.data_valid !== m_valid ||
            bus.usage !== (SZ+1)'(m_q.size()) || bus.empty !== (m_q.size() == 0) ||
            bus.full !== (m_q.size() == DEPTH) || bus.intr !== m_intr ||
            bus.drop_cnt !== 16'(m_drop)) begin
          n_err++;
          if (n_err <= 20)
            $display("FAIL cycle_model t=%0t: got data=%h valid=%b usage=%0d empty=%b full=%b int=%b drop=%0d, expected data=%h valid=%b usage=%0d int=%b drop=%0d",
                     $time, bus.data, bus.data_valid, bus.usage, bus.empty, bus.full, bus.intr,
                     bus.drop_cnt, m_data, m_valid, m_q.size(), m_intr, m_drop);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulses(input logic [CH-1:0][7:0] n);
    int mx = 0;
    for (int c = 0; c < CH; c++) if (int'(n[c]) > mx) mx = int'(n[c]);
    for (int p = 0; p < mx; p++) begin
      for (int c = 0; c < CH; c++) bus.pmt[c] = (p < int'(n[c]));
      tick(2);
      bus.pmt = '0;
      tick(2);
    end
  endtask

  task automatic window(input logic [CH-1:0][7:0] n, input int hold, input int gap);
    bus.gate = 1'b1;
    tick(2);
    pulses(n);
    tick(hold);
    bus.gate = 1'b0;
    tick(gap);
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
  endtask

  function automatic int low_word();
    return int'(bus.data[CH*W-1:0]);
  endfunction

  // ---------------- directed sequence ----------------
  initial begin : stim
    bus.gate = 1'b0; bus.pmt = '0; bus.rd_en = 1'b0; bus.clr_err = 1'b0;
    tick(3);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_usage", int'(bus.usage), 0);
    chk("rst_full",  int'(bus.full), 0);
    chk("rst_int",   int'(bus.intr), 0);
    chk("rst_data",  low_word(), 0);
    chk("rst_drop",  int'(bus.drop_cnt), 0);
    rst = 1'b0;
    tick(2);

    // 100-cycle gate, 3/0/5/7 pulses on ch0..ch3
    window({8'd7, 8'd5, 8'd0, 8'd3}, 70, 4);
    chk("t1_usage", int'(bus.usage), 1);
    pop();
    chk("t1_data",  low_word(), 32'h00E14003);
    chk("t1_valid", int'(bus.data_valid), 1);
    tick(1);
    chk("t1_valid_1cyc", int'(bus.data_valid), 0);
    chk("t1_empty", int'(bus.empty), 1);
    chk("t1_hold",  low_word(), 32'h00E14003);

    // saturation at 127
    window({8'd0, 8'd0, 8'd0, 8'd200}, 0, 4);
    pop();
    chk("t2_sat", low_word(), 127);

    // pulse one cycle after gate fall is ignored
    bus.gate = 1'b1; tick(2);
    pulses({8'd0, 8'd0, 8'd0, 8'd2});
    bus.gate = 1'b0; tick(1);
    bus.pmt = 4'b0001; tick(2);
    bus.pmt = '0; tick(4);
    pop();
    chk("t3_late_pulse", low_word(), 2);

    // back-to-back windows, 1-cycle gap
    window({8'd0, 8'd0, 8'd2, 8'd1}, 0, 1);
    window({8'd1, 8'd3, 8'd0, 8'd0}, 0, 4);
    chk("t3_b2b_usage", int'(bus.usage), 2);
    pop();
    chk("t3_b2b_w0", low_word(), 257);
    pop();
    chk("t3_b2b_w1", low_word(), 32'h0020C000);

    // INT threshold at 4
    for (int i = 0; i < 4; i++) window('0, 0, 1);
    tick(3);
    chk("t4_usage", int'(bus.usage), 4);
    chk("t4_int_on", int'(bus.intr), 1);
    pop();
    chk("t4_usage3", int'(bus.usage), 3);
    chk("t4_int_lag", int'(bus.intr), 1);
    tick(1);
    chk("t4_int_off", int'(bus.intr), 0);
    pop(); pop(); pop();
    tick(1);
    pop();
    chk("t4_empty_rd_valid", int'(bus.data_valid), 0);
    chk("t4_empty_rd_usage", int'(bus.usage), 0);

    // fill, overflow, pop with simultaneous commit
    for (int i = 0; i < DEPTH; i++) window('0, 0, 1);
    tick(4);
    chk("t5_fill_usage", int'(bus.usage), 1024);
    chk("t5_fill_full",  int'(bus.full), 1);
    chk("t5_fill_drop",  int'(bus.drop_cnt), 0);
    window('0, 0, 4);
    chk("t5_drop1", int'(bus.drop_cnt), 1);
    chk("t5_drop1_usage", int'(bus.usage), 1024);
    bus.gate = 1'b1; tick(2);
    bus.gate = 1'b0; tick(2);
    pop();
    chk("t5_pop_commit_drop",  int'(bus.drop_cnt), 2);
    chk("t5_pop_commit_usage", int'(bus.usage), 1023);
    chk("t5_pop_commit_valid", int'(bus.data_valid), 1);
    window('0, 0, 4);
    chk("t5_refill", int'(bus.usage), 1024);
    bus.gate = 1'b1; tick(2);
    bus.gate = 1'b0; tick(2);
    bus.clr_err = 1'b1; tick(1); bus.clr_err = 1'b0;
    chk("t5_clr_with_drop", int'(bus.drop_cnt), 1);
    tick(1);
    bus.clr_err = 1'b1; tick(1); bus.clr_err = 1'b0;
    chk("t5_clr", int'(bus.drop_cnt), 0);

    // reset mid-window, then fresh windows
    bus.gate = 1'b1; tick(2);
    pulses({8'd0, 8'd0, 8'd0, 8'd5});
    rst = 1'b1; bus.gate = 1'b0; tick(1);
    chk("t6_rst_usage", int'(bus.usage), 0);
    chk("t6_rst_empty", int'(bus.empty), 1);
    rst = 1'b0; tick(2);
    window({8'd0, 8'd0, 8'd0, 8'd2}, 0, 1);
    window('0, 0, 1);
    window('0, 0, 4);
    chk("t6_usage", int'(bus.usage), 3);
    pop();
    chk("t6_count2", low_word(), 2);
`ifdef MULTI_COUNT_FIFO_SEQ_EN
    chk("t6_tag0", int'(bus.data[WW-1 -: SEQ_W]), 0);
    pop();
    chk("t6_tag1", int'(bus.data[WW-1 -: SEQ_W]), 1);
    pop();
    chk("t6_tag2", int'(bus.data[WW-1 -: SEQ_W]), 2);
`else
    pop(); pop();
    chk("t6_drained", int'(bus.usage), 0);
`endif
    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
